// File: rtl/jpeg_byte_framer.sv
// Extracts SOI..EOI frames from an encoder byte stream into a FWFT output FIFO.
// Optional statistics counters are built when JPEG_FRAMER_STATS_EN is defined.
module jpeg_byte_framer #(
  parameter int FIFO_AW = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        in_deq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] frame_cnt,
  output logic [23:0] frame_len,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, FRAME, FLUSH} state_e;
  localparam int DEPTH = 1 << FIFO_AW;

  state_e             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [8:0]         out_q, out_d;
  logic [8:0]         mem_q [DEPTH];
  logic [8:0]         head;
  logic               fifo_full, fifo_empty, fifo_rd, fifo_wr;
  logic [8:0]         fifo_wdata;
  logic               accept, soi_hit, eoi_hit;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign out_valid  = !fifo_empty;
  // With the FIFO empty the last presented entry stays on the outputs.
  assign {out_last, out_data} = fifo_empty ? out_q : head;
  assign fifo_rd    = out_valid && out_ready;

  assign in_deq  = in_ready && (state_q != FLUSH) && !(hold_v_q && fifo_full);
  assign accept  = in_ready && in_deq;
  assign soi_hit = hold_v_q && (hold_q == 8'hFF) && (in_data == 8'hD8);
  assign eoi_hit = hold_v_q && (hold_q == 8'hFF) && (in_data == 8'hD9);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    fifo_wr    = 1'b0;
    fifo_wdata = {1'b0, hold_q};
    case (state_q)
      HUNT: if (accept) begin
        if (soi_hit) begin
          fifo_wr = 1'b1;
          hold_d  = 8'hD8;
          state_d = FRAME;
        end else begin
          hold_d   = in_data;
          hold_v_d = 1'b1;
        end
      end
      FRAME: if (accept) begin
        // A nested SOI is passed through as data; only FF D9 closes the frame.
        fifo_wr = 1'b1;
        hold_d  = in_data;
        if (eoi_hit) state_d = FLUSH;
      end
      FLUSH: if (!fifo_full || fifo_rd) begin
        fifo_wr    = 1'b1;
        fifo_wdata = {1'b1, hold_q};
        hold_v_d   = 1'b0;
        state_d    = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(fifo_wr);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(fifo_rd);
    out_d    = fifo_rd ? head : out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      hold_q   <= 8'h00;
      hold_v_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
    end
  end

  // NOTE: storage array has no reset; the pointers alone define FIFO contents.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= fifo_wdata;
  end

`ifdef JPEG_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic [23:0] frame_len_q, frame_len_d, len_q, len_d;
  logic        drop_inc, err_inc, frame_done;

  assign drop_inc   = (state_q == HUNT) && accept && hold_v_q && !soi_hit;
  assign err_inc    = (state_q == FRAME) && accept && soi_hit;
  assign frame_done = (state_q == FLUSH) && fifo_wr;

  always_comb begin
    len_d       = len_q;
    frame_len_d = frame_len_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    err_cnt_d   = err_cnt_q;
    // Every FIFO write belongs to a frame; the one issued from HUNT is the SOI FF.
    if (fifo_wr) len_d = (state_q == HUNT) ? 24'd1 : len_q + 24'd1;
    if (frame_done) begin
      frame_len_d = len_q + 24'd1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (err_inc && err_cnt_q != 16'hFFFF)   err_cnt_d  = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      frame_len_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign frame_len = frame_len_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign frame_len = '0;
  assign drop_cnt  = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_jpeg_byte_framer.sv
// Directed bench for jpeg_byte_framer (FIFO_AW=4); a frame-level scan model
// predicts the output stream, statistics are checked against hand values.
module tb_jpeg_byte_framer;

  typedef logic [7:0] q8_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_deq;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frame_cnt;
  logic [23:0] frame_len;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  bit rnd_ready = 1'b0;

  jpeg_byte_framer #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_data(in_data), .in_deq(in_deq),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_cnt(frame_cnt), .frame_len(frame_len), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: find each FF D8 pair, copy through the next FF D9 pair.
  // Bytes skipped while hunting are dropped, except the final one still held.
  task automatic model_load(input q8_t s);
    int n = s.size();
    int p = 0;
    while (p < n) begin
      int i = -1;
      int j = -1;
      for (int k = p; k + 1 < n; k++)
        if (s[k] == 8'hFF && s[k+1] == 8'hD8) begin i = k; break; end
      if (i < 0) break;
      for (int k = i + 2; k < n; k++)
        if (s[k-1] == 8'hFF && s[k] == 8'hD9) begin j = k; break; end
      if (j < 0) begin
        for (int k = i; k < n - 1; k++) exp_q.push_back({1'b0, s[k]});
        break;
      end
      for (int k = i; k <= j; k++) exp_q.push_back({(k == j), s[k]});
      p = j + 1;
    end
  endtask

  // Outputs are sampled mid-cycle; inputs only change at the falling edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {out_last, out_data}, 9'h1FF);
      else check("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) if (rnd_ready) out_ready = 1'($urandom_range(0, 1));

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_ready = 1'b1;
    in_data  = b;
    #1;
    while (!in_deq && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept", in_deq, 1);
    if (in_deq) @(posedge clk);
    #1 in_ready = 1'b0;
  endtask

  task automatic send(input q8_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last_data", {out_last, out_data}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_stats(input string name, input int fc, input int fl, input int dc, input int ec);
`ifdef JPEG_FRAMER_STATS_EN
    check({name, "_frame_cnt"}, frame_cnt, fc);
    check({name, "_frame_len"}, frame_len, fl);
    check({name, "_drop_cnt"}, drop_cnt, dc);
    check({name, "_err_cnt"}, err_cnt, ec);
`else
    check({name, "_frame_cnt"}, frame_cnt, 0);
    check({name, "_frame_len"}, frame_len, 0);
    check({name, "_drop_cnt"}, drop_cnt, 0);
    check({name, "_err_cnt"}, err_cnt, 0);
    if (fc + fl + dc + ec < 0) check("stats_args", 0, 1);
`endif
  endtask

  initial begin
    q8_t s;
    int stall_hi;
    #2;
    check("por_valid", out_valid, 0);
    check("por_last_data", {out_last, out_data}, 0);
    check_stats("por", 0, 0, 0, 0);
    #10 rst = 1'b1;

    // Basic frame with leading garbage.
    do_reset();
    s = '{8'h00, 8'h11, 8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD9};
    model_load(s);
    check("model_len_basic", exp_q.size(), 5);
    out_ready = 1'b1;
    send(s);
    drain();
    check_stats("basic", 1, 5, 2, 0);

    // Double FF before SOI, stuffed FF 00 inside.
    do_reset();
    s = '{8'hFF, 8'hFF, 8'hD8, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'hD9};
    model_load(s);
    send(s);
    drain();
    check_stats("stuff", 1, 7, 1, 0);

    // Nested SOI inside a frame.
    do_reset();
    s = '{8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD8, 8'hBB, 8'hFF, 8'hD9};
    model_load(s);
    send(s);
    drain();
    check_stats("nested", 1, 8, 0, 1);

    // Backpressure: 40-byte frame into a 16-deep FIFO with the sink stalled.
    do_reset();
    out_ready = 1'b0;
    s = '{8'hFF, 8'hD8};
    for (int i = 1; i <= 36; i++) s.push_back(8'(i));
    s.push_back(8'hFF);
    s.push_back(8'hD9);
    model_load(s);
    for (int i = 0; i < 17; i++) send_byte(s[i]);
    @(negedge clk);
    in_ready = 1'b1;
    in_data  = s[17];
    stall_hi = 0;
    repeat (6) begin
      #1 if (in_deq) stall_hi++;
      @(negedge clk);
    end
    in_ready = 1'b0;
    check("stall_after_17", stall_hi, 0);
    check("full_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 17; i < 40; i++) send_byte(s[i]);
    drain();
    check_stats("bp", 1, 40, 0, 0);

    // Reset in the middle of a frame.
    do_reset();
    out_ready = 1'b0;
    send('{8'hFF, 8'hD8, 8'hAA});
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1 check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last_data", {out_last, out_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    s = '{8'h55, 8'hFF, 8'hD8, 8'hFF, 8'hD9};
    model_load(s);
    out_ready = 1'b1;
    send(s);
    drain();
    check_stats("midrst", 1, 4, 1, 0);

    // Two frames with an RST marker, garbage between, random sink stalls.
    do_reset();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hD0, 8'h12, 8'hFF, 8'hD9, 8'h33,
          8'hFF, 8'hD8, 8'h44, 8'hFF, 8'hD9};
    model_load(s);
    rnd_ready = 1'b1;
    send(s);
    drain();
    rnd_ready = 1'b0;
    check_stats("two", 2, 5, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/jpeg_byte_framer.md
JPEG_BYTE_FRAMER -- requirements
Module: jpeg_byte_framer

Interface
REQ-001 SHALL have parameter FIFO_AW, default 11; output FIFO depth is 2**FIFO_AW bytes.
REQ-002 SHALL have port clk, input, 1 bit: clock; every register updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_ready, input, 1 bit: the encoder holds a JPEG byte on in_data.
REQ-005 SHALL have port in_data, input, 8 bits: JPEG byte from the encoder, valid while in_ready=1.
REQ-006 SHALL have port in_deq, output, 1 bit: pops the encoder byte; the byte counts as accepted in any cycle where in_ready && in_deq.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data and out_last are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: sink accepts the byte; transfer = out_valid && out_ready.
REQ-009 SHALL have port out_data, output, 8 bits: framed JPEG byte.
REQ-010 SHALL have port out_last, output, 1 bit: high only with the D9 byte of an EOI marker.
REQ-011 SHALL have port frame_cnt, output, 16 bits: number of completed frames, wrapping.
REQ-012 SHALL have port frame_len, output, 24 bits: byte length of the last completed frame, SOI and EOI included.
REQ-013 SHALL have port drop_cnt, output, 16 bits: bytes discarded outside frames, saturating.
REQ-014 SHALL have port err_cnt, output, 16 bits: SOI markers found inside a frame, saturating.

Function
REQ-015 SHALL keep one-byte hold register (hold, hold_v); every accepted byte passes through hold before FIFO write.
REQ-016 SHALL drive in_deq = in_ready && state!=FLUSH && !(hold_v && fifo_full) combinationally; encoder bytes are never lost.
REQ-017 SHALL implement FSM with states HUNT, FRAME, FLUSH.
REQ-018 HUNT, on accepted byte: if hold_v && hold==FF && byte==D8, write FF to FIFO, load hold=D8, go to FRAME; otherwise discard hold (drop_cnt+1 if hold_v) and load hold with the byte.
REQ-019 FRAME, on accepted byte: write hold to FIFO (last=0), load hold with the byte; if hold==FF && byte==D9, go to FLUSH.
REQ-020 FRAME, hold==FF && byte==D8: SHALL pass both bytes as data, stay in FRAME, err_cnt+1.
REQ-021 FRAME: FF00 stuffing and RSTn markers SHALL pass unchanged with last=0.
REQ-022 FLUSH: in_deq=0; when FIFO not full, write hold (D9) with last=1, clear hold_v, go to HUNT.
REQ-023 FIFO entries SHALL be 9 bits {last,data}, first-word-fall-through; a byte written at edge E is presented on out_data with out_valid=1 from edge E+1.
REQ-024 FIFO full: no write; simultaneous read and write when full SHALL be allowed only as read-then-write in the same cycle, with no loss.
REQ-025 FIFO empty: out_valid=0; out_data/out_last hold their last values.
REQ-026 Frame length counter SHALL count FIFO writes from the SOI FF through the EOI D9, latch into frame_len at the FLUSH write, and increment frame_cnt in that cycle.

Reset
REQ-027 rst=0 SHALL asynchronously force: state=HUNT, hold_v=0, FIFO empty, out_valid=0, out_last=0, out_data=0, all counters=0.
REQ-028 Reset mid-frame SHALL discard all buffered bytes; the first bytes after release are treated in HUNT.

Configuration
REQ-029 With macro JPEG_FRAMER_STATS_EN defined, SHALL implement frame_cnt, frame_len, drop_cnt and err_cnt per REQ-011..014.
REQ-030 Without JPEG_FRAMER_STATS_EN, SHALL tie those four outputs to 0 and synthesize no counter registers; framing behaviour SHALL be identical.

Verification
REQ-031 Stream 00 11 FF D8 AA FF D9, out_ready=1 -> output FF D8 AA FF D9, out_last only on D9; drop_cnt=2, frame_cnt=1, frame_len=5.
REQ-032 Stream FF FF D8 01 FF 00 FF D9 -> output FF D8 01 FF 00 FF D9; drop_cnt=1; no out_last on stuffed 00.
REQ-033 FIFO_AW=4, out_ready=0, 40-byte frame -> in_deq falls after 17 accepted bytes; releasing out_ready yields all 40 bytes in order, none lost.
REQ-034 FF D8 AA FF D8 BB FF D9 -> all 8 bytes output, err_cnt=1, frame_len=8, one out_last.
REQ-035 rst pulsed low after FF D8 AA -> out_valid=0 immediately; then 55 FF D8 FF D9 -> output FF D8 FF D9 only, drop_cnt=1.
REQ-036 Build without JPEG_FRAMER_STATS_EN, rerun REQ-031 -> identical output stream; all stats outputs 0.
